seq_load_packer: RTL

//  Load-side counterpart of the store pipeline: consumes AXI R beats for a vector load and packs the

---
 rtl/seq_load_packer_pkg.sv | 40 ++++
 rtl/seq_load_packer_seq_byte_shifter.sv | 32 +++
 rtl/seq_load_packer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seq_load_packer_pkg.sv
// Shared types and default configuration for the load-side sequential packer.
package seq_load_packer_pkg;

  localparam int unsigned DLEN           = 64;
  localparam int unsigned NR_LANES_DEF   = 4;
  localparam int unsigned AXI_DW_DEF     = 128;
  localparam int unsigned MAX_TXN_DEF    = 4096;

  localparam int unsigned BUF_BYTES_DEF  = NR_LANES_DEF * DLEN / 8;
  localparam int unsigned BUS_BYTES_DEF  = AXI_DW_DEF / 8;
  localparam int unsigned TXN_W_DEF      = $clog2(MAX_TXN_DEF) + 1;
  localparam int unsigned BOFF_W_DEF     = $clog2(BUS_BYTES_DEF);
  localparam int unsigned SEQ_NB_W_DEF   = $clog2(BUF_BYTES_DEF) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pkr_state_e;

  // Packed buffer as seen downstream, default configuration.
  typedef struct packed {
    logic [BUF_BYTES_DEF*8-1:0] data;
    logic [SEQ_NB_W_DEF-1:0]    nbytes;
    logic                       last;
  } seq_buf_t;

  // Per-burst control word, default configuration.
  typedef struct packed {
    logic [BOFF_W_DEF-1:0] boff;
    logic [TXN_W_DEF-1:0]  nbytes;
  } ld_txn_ctrl_t;

  function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_load_packer_seq_byte_shifter.sv
// Moves beat bytes [off_i +: n_i] to buffer bytes [ptr_i +: n_i]; be_o marks the written bytes.
module seq_byte_shifter #(
  parameter int unsigned BusBytes = 16,
  parameter int unsigned BufBytes = 32,
  parameter int unsigned OffW     = 5,
  parameter int unsigned PtrW     = 6
) (
  input  logic [BusBytes*8-1:0] beat_i,
  input  logic [OffW-1:0]       off_i,
  input  logic [OffW-1:0]       n_i,
  input  logic [PtrW-1:0]       ptr_i,
  output logic [BufBytes*8-1:0] data_o,
  output logic [BufBytes-1:0]   be_o
);

  // Per destination byte: select the matching source byte when it falls inside the window.
  always_comb begin
    data_o = '0;
    be_o   = '0;
    for (int j = 0; j < BufBytes; j++) begin
      int k;
      int src;
      k   = j - int'(ptr_i);
      src = int'(off_i) + k;
      if (k >= 0 && k < int'(n_i) && src < int'(BusBytes)) begin
        be_o[j]          = 1'b1;
        data_o[j*8 +: 8] = beat_i[src*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/seq_load_packer.sv
// Packs valid bytes of AXI R beats contiguously into lane-wide buffers for the shuffle unit.
//
//  state | meaning
//  IDLE  | waiting for instruction meta (total byte count)
//  RUN   | accepting bursts, packing beats, emitting buffers until the instruction completes
module seq_load_packer
  import seq_load_packer_pkg::*;
#(
  parameter int unsigned NrLanes      = NR_LANES_DEF,
  parameter int unsigned AxiDataWidth = AXI_DW_DEF,
  parameter int unsigned MaxTxnBytes  = MAX_TXN_DEF,
  localparam int unsigned BufBytes    = NrLanes * DLEN / 8,
  localparam int unsigned BusBytes    = AxiDataWidth / 8,
  localparam int unsigned TxnW        = $clog2(MaxTxnBytes) + 1,
  localparam int unsigned BoffW       = $clog2(BusBytes),
  localparam int unsigned OffW        = BoffW + 1,
  localparam int unsigned PtrW        = $clog2(BufBytes) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    meta_valid_i,
  output logic                    meta_ready_o,
  input  logic [31:0]             meta_nbytes_i,
  input  logic                    txn_valid_i,
  output logic                    txn_ready_o,
  input  logic [BoffW-1:0]        txn_boff_i,
  input  logic [TxnW-1:0]         txn_nbytes_i,
  input  logic                    axi_r_valid_i,
  output logic                    axi_r_ready_o,
  input  logic [AxiDataWidth-1:0] axi_r_data_i,
  input  logic                    axi_r_last_i,
  input  logic [1:0]              axi_r_resp_i,
  output logic                    seq_valid_o,
  input  logic                    seq_ready_i,
  output logic [BufBytes*8-1:0]   seq_data_o,
  output logic [PtrW-1:0]         seq_nbytes_o,
  output logic                    seq_last_o,
  output logic                    err_o
);

  pkr_state_e            state_q, state_d;
  logic [31:0]           ins_rem_q, ins_rem_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic                  act_q, act_d;
  logic [OffW-1:0]       beat_off_q, beat_off_d;
  logic [TxnW-1:0]       txn_rem_q, txn_rem_d;
  logic [TxnW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [TxnW-1:0]       exp_beats_q, exp_beats_d;
  logic [BufBytes*8-1:0] buf_q, buf_d;
  logic                  seq_valid_q, seq_valid_d;
  logic [PtrW-1:0]       seq_nb_q, seq_nb_d;
  logic                  seq_last_q, seq_last_d;
  logic                  err_q, err_d;

  logic [31:0]           n_w;
  logic [OffW-1:0]       n;
  logic                  consume, pop, txn_hs, final_beat;
  logic [BufBytes*8-1:0] placed;
  logic [BufBytes-1:0]   be;

  // Bytes movable this cycle: bounded by what is left in the beat, the burst and the buffer.
  assign n_w = min3(32'(BusBytes) - 32'(beat_off_q), 32'(txn_rem_q),
                    32'(BufBytes) - 32'(wr_ptr_q));
  assign n   = OffW'(n_w);

  assign meta_ready_o  = (state_q == IDLE);
  assign txn_ready_o   = (state_q == RUN) && !act_q && (ins_rem_q != '0);
  assign txn_hs        = txn_ready_o && txn_valid_i;
  assign consume       = (state_q == RUN) && act_q && axi_r_valid_i && !seq_valid_q;
  // A beat is only popped once fully used or once the burst ends inside it; otherwise the
  // remainder spills into the next buffer.
  assign pop           = consume && ((32'(beat_off_q) + n_w == 32'(BusBytes)) ||
                                     (32'(txn_rem_q) == n_w));
  assign final_beat    = (beat_cnt_q == exp_beats_q - TxnW'(1));
  assign axi_r_ready_o = pop;

  assign seq_valid_o  = seq_valid_q;
  assign seq_data_o   = buf_q;
  assign seq_nbytes_o = seq_nb_q;
  assign seq_last_o   = seq_last_q;
  assign err_o        = err_q;

  seq_byte_shifter #(
    .BusBytes(BusBytes),
    .BufBytes(BufBytes),
    .OffW    (OffW),
    .PtrW    (PtrW)
  ) u_shifter (
    .beat_i(axi_r_data_i),
    .off_i (beat_off_q),
    .n_i   (n),
    .ptr_i (wr_ptr_q),
    .data_o(placed),
    .be_o  (be)
  );

  // Next-state: instruction/burst bookkeeping, packing and buffer emission.
  always_comb begin
    state_d     = state_q;
    ins_rem_d   = ins_rem_q;
    wr_ptr_d    = wr_ptr_q;
    act_d       = act_q;
    beat_off_d  = beat_off_q;
    txn_rem_d   = txn_rem_q;
    beat_cnt_d  = beat_cnt_q;
    exp_beats_d = exp_beats_q;
    buf_d       = buf_q;
    seq_valid_d = seq_valid_q;
    seq_nb_d    = seq_nb_q;
    seq_last_d  = seq_last_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (meta_valid_i) begin
          state_d   = RUN;
          ins_rem_d = meta_nbytes_i;
          wr_ptr_d  = '0;
        end
      end
      RUN: begin
        if (txn_hs) begin
          act_d       = 1'b1;
          beat_off_d  = OffW'(txn_boff_i);
          txn_rem_d   = txn_nbytes_i;
          beat_cnt_d  = '0;
          exp_beats_d = TxnW'((32'(txn_boff_i) + 32'(txn_nbytes_i) + 32'(BusBytes) - 32'd1)
                              >> BoffW);
        end
        if (seq_valid_q) begin
          if (seq_ready_i) begin
            seq_valid_d = 1'b0;
            seq_nb_d    = '0;
            seq_last_d  = 1'b0;
            wr_ptr_d    = '0;
            buf_d       = '0;
            if (seq_last_q) state_d = IDLE;
          end
        end else if (consume) begin
          for (int b = 0; b < BufBytes; b++) begin
            if (be[b]) buf_d[b*8 +: 8] = placed[b*8 +: 8];
          end
          wr_ptr_d   = wr_ptr_q + PtrW'(n);
          txn_rem_d  = txn_rem_q - TxnW'(n);
          ins_rem_d  = ins_rem_q - 32'(n);
          beat_off_d = beat_off_q + n;
          if (pop) begin
            beat_off_d = '0;
            beat_cnt_d = beat_cnt_q + TxnW'(1);
            err_d      = (axi_r_resp_i != 2'b00) || (axi_r_last_i != final_beat);
          end
          if (txn_rem_d == '0) act_d = 1'b0;
          if (wr_ptr_d == PtrW'(BufBytes) || ins_rem_d == '0) begin
            seq_valid_d = 1'b1;
            seq_nb_d    = wr_ptr_d;
            seq_last_d  = (ins_rem_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any partial buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ins_rem_q   <= '0;
      wr_ptr_q    <= '0;
      act_q       <= 1'b0;
      beat_off_q  <= '0;
      txn_rem_q   <= '0;
      beat_cnt_q  <= '0;
      exp_beats_q <= '0;
      buf_q       <= '0;
      seq_valid_q <= 1'b0;
      seq_nb_q    <= '0;
      seq_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ins_rem_q   <= ins_rem_d;
      wr_ptr_q    <= wr_ptr_d;
      act_q       <= act_d;
      beat_off_q  <= beat_off_d;
      txn_rem_q   <= txn_rem_d;
      beat_cnt_q  <= beat_cnt_d;
      exp_beats_q <= exp_beats_d;
      buf_q       <= buf_d;
      seq_valid_q <= seq_valid_d;
      seq_nb_q    <= seq_nb_d;
      seq_last_q  <= seq_last_d;
      err_q       <= err_d;
    end
  end

endmodule
